// File: rtl/axil_cfg_pkg.sv
// rtl/axil_cfg_pkg.sv - shared types and defaults for the AXI4-Lite config sequencer; verify states exist only with AXIL_CFG_WR_VERIFY_EN
package axil_cfg_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
`ifdef AXIL_CFG_WR_VERIFY_EN
      VERIFY_REQ,
      VERIFY_DATA,
`endif
      RSP
   } seq_state_t;

   typedef struct packed {
      logic                      write;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
      logic [DEF_STRB_WIDTH-1:0] wstrb;
   } cmd_t;

endpackage

// File: rtl/axil_cfg_strb_cmp.sv
// rtl/axil_cfg_strb_cmp.sv - combinational byte-masked compare of readback data against written data
module axil_cfg_strb_cmp #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [DATA_WIDTH-1:0]   ref_data,
   input  logic [DATA_WIDTH/8-1:0] strb,
   output logic                    mismatch
);

   // flag a mismatch if any strobed byte differs; unstrobed bytes are don't-care
   always_comb begin
      mismatch = 1'b0;
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         if (strb[i] && (rdata[8*i +: 8] != ref_data[8*i +: 8])) begin
            mismatch = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axil_cfg_sequencer.sv
// rtl/axil_cfg_sequencer.sv - single-outstanding AXI4-Lite master FSM; AXIL_CFG_WR_VERIFY_EN adds write readback verify
module axil_cfg_sequencer
   import axil_cfg_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_mismatch,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic                    RVALID,
   output logic                    RREADY
);

   seq_state_t state;
   logic       aw_done;
   logic       w_done;
   logic       aw_hs;
   logic       w_hs;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;

`ifdef AXIL_CFG_WR_VERIFY_EN
   logic verify_mismatch;

   // AWADDR/WDATA/WSTRB are held after the write, so they double as the latched command
   axil_cfg_strb_cmp #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_strb_cmp (
      .rdata    (RDATA),
      .ref_data (WDATA),
      .strb     (WSTRB),
      .mismatch (verify_mismatch)
   );
`else
   assign rsp_mismatch = 1'b0;
`endif

   // command sequencing FSM; every output is registered so no valid depends on a ready
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         AWADDR    <= '0;
         AWVALID   <= 1'b0;
         WDATA     <= '0;
         WSTRB     <= '0;
         WVALID    <= 1'b0;
         BREADY    <= 1'b0;
         ARADDR    <= '0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
`ifdef AXIL_CFG_WR_VERIFY_EN
         rsp_mismatch <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     AWADDR  <= cmd_addr;
                     WDATA   <= cmd_wdata;
                     WSTRB   <= cmd_wstrb;
                     AWVALID <= 1'b1;
                     WVALID  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                     state   <= WR_REQ;
                  end else begin
                     ARADDR  <= cmd_addr;
                     ARVALID <= 1'b1;
                     state   <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  AWVALID <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  WVALID <= 1'b0;
                  w_done <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  BREADY <= 1'b1;
                  state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (BVALID && BREADY) begin
                  BREADY <= 1'b0;
`ifdef AXIL_CFG_WR_VERIFY_EN
                  ARADDR  <= AWADDR;
                  ARVALID <= 1'b1;
                  state   <= VERIFY_REQ;
`else
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
`endif
               end
            end
            RD_REQ: begin
               if (ARVALID && ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (RVALID && RREADY) begin
                  rsp_rdata <= RDATA;
                  RREADY    <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end
            end
`ifdef AXIL_CFG_WR_VERIFY_EN
            VERIFY_REQ: begin
               if (ARVALID && ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= VERIFY_DATA;
               end
            end
            VERIFY_DATA: begin
               if (RVALID && RREADY) begin
                  rsp_rdata    <= RDATA;
                  rsp_mismatch <= verify_mismatch;
                  RREADY       <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end
            end
`endif
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
`ifdef AXIL_CFG_WR_VERIFY_EN
                  rsp_mismatch <= 1'b0;
`endif
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// tb/tb_axil_cfg_sequencer.sv - randomized self-checking bench with register-file slave and command-level model
module tb_axil_cfg_sequencer;
   import axil_cfg_pkg::*;

   localparam int AW = DEF_ADDR_WIDTH;
   localparam int DW = DEF_DATA_WIDTH;
   localparam int SW = DEF_STRB_WIDTH;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_mismatch;
   logic [AW-1:0] AWADDR;
   logic          AWVALID;
   logic          AWREADY = 1'b0;
   logic [DW-1:0] WDATA;
   logic [SW-1:0] WSTRB;
   logic          WVALID;
   logic          WREADY = 1'b0;
   logic          BVALID = 1'b0;
   logic          BREADY;
   logic [AW-1:0] ARADDR;
   logic          ARVALID;
   logic          ARREADY = 1'b0;
   logic [DW-1:0] RDATA = '0;
   logic          RVALID = 1'b0;
   logic          RREADY;

   always #5 ACLK = ~ACLK;

   axil_cfg_sequencer dut (
      .ACLK (ACLK), .ARESETn (ARESETn),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
      .rsp_mismatch (rsp_mismatch),
      .AWADDR (AWADDR), .AWVALID (AWVALID), .AWREADY (AWREADY),
      .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
      .BVALID (BVALID), .BREADY (BREADY),
      .ARADDR (ARADDR), .ARVALID (ARVALID), .ARREADY (ARREADY),
      .RDATA (RDATA), .RVALID (RVALID), .RREADY (RREADY)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // slave / monitor state
   logic [DW-1:0] slave_mem [4];
   logic [DW-1:0] mem_model [4];
   int            rdy_pct = 100;
   bit            stall_w = 0;
   bit            b_hold = 0;
   bit            corrupt_rd = 0;
   int            stall_cnt = 0;
   bit            aw_got = 0, w_got = 0, b_owed = 0, r_owed = 0, r_shown = 0;
   bit            p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
   logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
   logic [DW-1:0] s_wdata = '0;
   logic [SW-1:0] s_wstrb = '0;
   logic          prev_awv = 0, prev_wv = 0, prev_arv = 0, prev_bready = 0, prev_rready = 0;
   logic          prev_rsp_valid = 0, prev_rsp_ready = 0;
   logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
   logic [DW-1:0] prev_wdata = '0, prev_rsp_rdata = '0;
   logic [SW-1:0] prev_wstrb = '0;
   logic [DW-1:0] last_rdata;
   logic          last_mis;

   function automatic bit rnd();
      return ($urandom_range(99) < rdy_pct);
   endfunction

   task automatic slave_step();
      logic [DW-1:0] mask;
      if (!ARESETn) begin
         AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RDATA = '0;
         aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0; r_shown = 0; stall_cnt = 0;
         p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
         prev_awv = 0; prev_wv = 0; prev_arv = 0; prev_bready = 0; prev_rready = 0;
         prev_rsp_valid = 0; prev_rsp_ready = 0;
         for (int i = 0; i < 4; i++) slave_mem[i] = '0;
      end else begin
         // effects of the handshakes that completed at the last rising edge
         if (p_aw) begin aw_got = 1; s_awaddr = prev_awaddr; end
         if (p_w) begin w_got = 1; s_wdata = prev_wdata; s_wstrb = prev_wstrb; end
         if (p_b) b_owed = 0;
         if (p_ar) begin r_owed = 1; r_shown = 0; s_araddr = prev_araddr; end
         if (p_r) r_owed = 0;
         if (aw_got && w_got) begin
            for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{s_wstrb[b]}};
            slave_mem[s_awaddr[3:2]] = (slave_mem[s_awaddr[3:2]] & ~mask) | (s_wdata & mask);
            aw_got = 0; w_got = 0; b_owed = 1; stall_cnt = 0;
         end

         // protocol observations
         if (p_aw) check("awvalid_drop", AWVALID, 0);
         else if (prev_awv) begin
            check("awvalid_hold", AWVALID, 1);
            check("awaddr_stable", AWADDR, prev_awaddr);
         end
         if (p_w) check("wvalid_drop", WVALID, 0);
         else if (prev_wv) begin
            check("wvalid_hold", WVALID, 1);
            check("wdata_stable", {WSTRB, WDATA}, {prev_wstrb, prev_wdata});
         end
         if (p_ar) check("arvalid_drop", ARVALID, 0);
         else if (prev_arv) begin
            check("arvalid_hold", ARVALID, 1);
            check("araddr_stable", ARADDR, prev_araddr);
         end
         if ((AWVALID && !prev_awv) || (WVALID && !prev_wv))
            check("aw_w_together", {AWVALID, WVALID}, 2'b11);
         if (BREADY && !prev_bready) check("bready_after_aw_w", {b_owed, AWVALID, WVALID}, 3'b100);
         if (RREADY && !prev_rready) check("rready_after_ar", {r_owed, ARVALID}, 2'b10);
         if (p_b) check("bready_drop", BREADY, 0);
         if (p_r) check("rready_drop", RREADY, 0);
         if (rsp_valid)
            check("axi_idle_in_rsp", {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready}, 0);
         if (prev_rsp_valid && !prev_rsp_ready) begin
            check("rsp_valid_hold", rsp_valid, 1);
            check("rsp_rdata_stable", rsp_rdata, prev_rsp_rdata);
         end

         // slave responses for the next rising edge
         if (stall_w) begin
            AWREADY = !aw_got && !b_owed;
            if (aw_got && !w_got) stall_cnt++;
            WREADY = aw_got && !w_got && (stall_cnt > 3);
         end else begin
            AWREADY = !aw_got && !b_owed && rnd();
            WREADY  = !w_got && !b_owed && rnd();
         end
         if (b_owed) BVALID = !b_hold && (BVALID || rnd());
         else        BVALID = ($urandom_range(9) == 0);
         ARREADY = !r_owed && rnd();
         if (r_owed) begin
            if (!r_shown) begin
               if (rnd()) begin
                  RVALID  = 1;
                  RDATA   = slave_mem[s_araddr[3:2]] ^ (corrupt_rd ? 32'h1 : 32'h0);
                  r_shown = 1;
               end else begin
                  RVALID = 0;
               end
            end
         end else begin
            RVALID = ($urandom_range(9) == 0);
            RDATA  = $urandom;
         end

         p_aw = AWVALID && AWREADY;
         p_w  = WVALID && WREADY;
         p_b  = BVALID && BREADY;
         p_ar = ARVALID && ARREADY;
         p_r  = RVALID && RREADY;
         prev_awv = AWVALID; prev_awaddr = AWADDR;
         prev_wv = WVALID; prev_wdata = WDATA; prev_wstrb = WSTRB;
         prev_arv = ARVALID; prev_araddr = ARADDR;
         prev_bready = BREADY; prev_rready = RREADY;
         prev_rsp_valid = rsp_valid; prev_rsp_ready = rsp_ready; prev_rsp_rdata = rsp_rdata;
      end
   endtask

   initial forever begin
      @(negedge ACLK);
      slave_step();
   end

   task automatic tick();
      @(posedge ACLK);
      #2;
   endtask

   task automatic run_cmd(input cmd_t c, input int hold, input bit corrupt);
      logic [DW-1:0] mask;
      logic [DW-1:0] exp_rdata;
      logic          exp_mis;
      int            n;
      for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{c.wstrb[b]}};
      exp_mis = 0;
      if (c.write) begin
         mem_model[c.addr[3:2]] = (mem_model[c.addr[3:2]] & ~mask) | (c.wdata & mask);
`ifdef AXIL_CFG_WR_VERIFY_EN
         exp_rdata = mem_model[c.addr[3:2]] ^ (corrupt ? 32'h1 : 32'h0);
         for (int b = 0; b < SW; b++)
            if (c.wstrb[b] && (exp_rdata[8*b +: 8] != c.wdata[8*b +: 8])) exp_mis = 1;
`else
         exp_rdata = '0;
`endif
      end else begin
         exp_rdata = mem_model[c.addr[3:2]];
      end
      corrupt_rd = corrupt;
      n = 0;
      while (!cmd_ready && n < 100) begin tick(); n++; end
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1; cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
      tick();
      cmd_valid = 0;
      check("cmd_ready_drop", cmd_ready, 0);
      n = 0;
      while (!rsp_valid && n < 400) begin tick(); n++; end
      check("rsp_valid_rise", rsp_valid, 1);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("cmd_ready_in_rsp", cmd_ready, 0);
      end
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_mismatch", rsp_mismatch, exp_mis);
      last_rdata = rsp_rdata;
      last_mis   = rsp_mismatch;
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      check("rsp_valid_drop", rsp_valid, 0);
      check("cmd_ready_back", cmd_ready, 1);
      corrupt_rd = 0;
   endtask

   function automatic cmd_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      cmd_t c;
      c.write = w; c.addr = a; c.wdata = d; c.wstrb = s;
      return c;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 4; i++) mem_model[i] = '0;

      // reset state
      tick(); tick();
      check("reset_ctrl", {cmd_ready, rsp_valid, rsp_mismatch, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
      check("reset_data", {rsp_rdata, AWADDR, ARADDR}, 0);
      ARESETn = 1;
      #1 check("cmd_ready_at_release", cmd_ready, 0);
      tick();
      check("cmd_ready_after_release", cmd_ready, 1);

      // basic write then read back
      rdy_pct = 100;
      run_cmd(mk(1, 4'h4, 32'hDEADBEEF, 4'hF), 0, 0);
      run_cmd(mk(0, 4'h4, 32'h0, 4'h0), 0, 0);
      check("read_deadbeef", last_rdata, 32'hDEADBEEF);

      // partial strobe merge
      rdy_pct = 60;
      run_cmd(mk(1, 4'h8, 32'h11223344, 4'hF), 0, 0);
      run_cmd(mk(1, 4'h8, 32'hAABBCCDD, 4'h5), 0, 0);
      run_cmd(mk(0, 4'h8, 32'h0, 4'h0), 0, 0);
      check("read_merge", last_rdata, 32'h11BB33DD);

      // response back-pressure
      run_cmd(mk(0, 4'hC, 32'h0, 4'h0), 5, 0);

      // W channel stall after AW accepted
      stall_w = 1;
      run_cmd(mk(1, 4'hC, 32'hCAFEF00D, 4'hF), 0, 0);
      stall_w = 0;
      run_cmd(mk(0, 4'hC, 32'h0, 4'h0), 0, 0);

      // reset while waiting for the write response
      rdy_pct = 100;
      b_hold = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
      tick();
      cmd_valid = 0;
      n = 0;
      while (!BREADY && n < 50) begin tick(); n++; end
      check("reached_wr_resp", BREADY, 1);
      tick(); tick();
      ARESETn = 0;
      #1 check("async_reset_outputs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
      tick(); tick();
      b_hold = 0;
      for (int i = 0; i < 4; i++) mem_model[i] = '0;
      ARESETn = 1;
      #1 check("cmd_ready_release_0", cmd_ready, 0);
      tick();
      check("cmd_ready_release_1", cmd_ready, 1);
      run_cmd(mk(0, 4'h0, 32'h0, 4'h0), 0, 0);

      // randomized traffic
      for (int k = 0; k < 200; k++) begin
         rdy_pct = $urandom_range(100, 30);
         run_cmd(mk($urandom_range(1), AW'($urandom), $urandom, SW'($urandom)), $urandom_range(2), 0);
      end

`ifdef AXIL_CFG_WR_VERIFY_EN
      rdy_pct = 100;
      run_cmd(mk(1, 4'h0, 32'h000000FF, 4'h1), 0, 1);
      check("verify_strb1_mismatch", last_mis, 1);
      run_cmd(mk(1, 4'h0, 32'h000000FF, 4'h2), 0, 1);
      check("verify_strb2_mismatch", last_mis, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_cfg_sequencer.md
Name: axil_cfg_sequencer

Overview:
- Single-outstanding AXI4-Lite master controller that turns a simple command/response interface into AXI4-Lite write or read transactions.
- It is the block that sequences register-file slaves (4 x 32-bit words, byte strobes, no BRESP/RRESP) from configuration logic or a test host.
- One command is in flight at a time; each command completes only after the AXI response handshake.

Parameters:
- ADDR_WIDTH, 4, width of the byte address; word index is addr[3:2].
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  command complete
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_mismatch  out  1  verify failure; only meaningful with the macro, else tied 0
- AWADDR/AWVALID out ADDR_WIDTH/1; AWREADY in 1  write address channel
- WDATA/WSTRB/WVALID out DATA_WIDTH/DATA_WIDTH/8/1; WREADY in 1  write data channel
- BVALID in 1; BREADY out 1  write response channel
- ARADDR/ARVALID out ADDR_WIDTH/1; ARREADY in 1  read address channel
- RDATA in DATA_WIDTH; RVALID in 1; RREADY out 1  read data channel

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, command registers cleared.
- Any in-flight AXI transaction is abandoned on reset; the slave is reset on the same net.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1 (registered; asserted the cycle after reset release).
  - On handshake, latch cmd fields and drop cmd_ready.
  - Write command: assert AWVALID and WVALID in the same cycle, go to WR_REQ.
  - Read command: assert ARVALID, go to RD_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together, with AWADDR/WDATA/WSTRB held stable.
  - Each valid deasserts independently on its own ready handshake; flags aw_done/w_done track this.
  - If AWREADY and WREADY arrive in the same cycle, both drop together.
  - When both handshakes are done, assert BREADY and go to WR_RESP.
- WR_RESP: on BVALID && BREADY, drop BREADY and go to RSP with rsp_rdata=0.
- RD_REQ: hold ARVALID/ARADDR until ARREADY; on handshake drop ARVALID, assert RREADY, go to RD_DATA.
- RD_DATA: on RVALID && RREADY, capture RDATA into rsp_rdata, drop RREADY, go to RSP.
- RSP:
  - rsp_valid=1 with rsp_rdata stable until rsp_ready.
  - On the handshake, drop rsp_valid, return to IDLE, re-assert cmd_ready.
  - No back-to-back overlap: at least one IDLE cycle between commands.
- AXI valids never deassert before their ready, and never depend combinationally on ready.
- Minimum latency:
  - Write: 2 cycles from AW/W assert to B handshake plus 1 RSP cycle.
  - Read: 1 cycle from AR handshake to R plus RSP.
  - The bench checks the actual handshake sequence, not an exact latency.
- BVALID or RVALID arriving outside WR_RESP/RD_DATA is ignored (READY is low).

Optional Feature:
- Macro: AXIL_CFG_WR_VERIFY_EN.
- With it defined:
  - After a write's B handshake, the FSM issues a read to the same address (states VERIFY_REQ, VERIFY_DATA).
  - It compares RDATA against the latched wdata on strobed bytes only.
  - rsp_mismatch=1 if any strobed byte differs; rsp_rdata returns the readback value.
  - Write latency grows by one full read.
- Without it: the verify states are not compiled, rsp_mismatch is tied 0, and writes return rsp_rdata=0.

Decomposition:
- Package axil_cfg_pkg holds:
  - seq_state_t enum;
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - a cmd_t struct {write, addr, wdata, wstrb}.
- One natural sub-module, axil_cfg_strb_cmp: combinational byte-masked compare used only under the macro.
- The FSM stays in the top module.

Test Plan:
- Write addr 0x4, wdata 0xDEADBEEF, strb 0xF; then read 0x4 -> rsp_rdata=0xDEADBEEF, AW/W asserted together, each dropped only after its own ready.
- Write 0x8 data 0x11223344 strb 0xF, then write 0x8 data 0xAABBCCDD strb 0x5; read 0x8 -> 0x11BB33DD.
- Hold rsp_ready=0 for 5 cycles after a read of 0xC -> rsp_valid and rsp_rdata stay stable, cmd_ready stays 0, no new AXI valid is driven.
- Slave stalls WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID holds with stable WDATA, BREADY asserts only after both handshakes.
- Assert ARESETn low while in WR_RESP -> all AXI valids/readies and rsp_valid go 0 immediately; cmd_ready returns 1 one cycle after release.
- With AXIL_CFG_WR_VERIFY_EN, a slave model corrupting byte 0 on write 0x0 data 0x000000FF strb 0x1 -> rsp_mismatch=1; same case with strb 0x2 -> rsp_mismatch=0.
